exe_mul_sequencer: RTL and testbench

Iterative shift-add multiply controller beside the EXE stage ALU.
- Accepts MUL (and optionally MLA) operands from the ID/EX register.
- Stalls the front of the pipeline while iterating.
- Returns the low N bits of the product with N/Z flags and a status-register write pulse.
- The ALU stays single-cycle; this block sequences the multi-cycle path and shares the status-register write port.

---
 rtl/exe_pkg.sv | 31 +++
 rtl/mul_shift_add_dp.sv | 63 ++++++
 rtl/exe_mul_sequencer.sv | 99 +++++++++
 tb/tb_exe_mul_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: multiply sequencer states, status bit
// positions, the MUL command code and the flag merge helper.
package exe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  localparam logic [3:0] EXE_MUL = 4'b0010;

  // N and Z come from the product, C and V pass through untouched
  function automatic logic [3:0] mul_flags(
    input logic [3:0] st_i,
    input logic       neg_i,
    input logic       zero_i
  );
    logic [3:0] f;
    f        = st_i;
    f[N_BIT] = neg_i;
    f[Z_BIT] = zero_i;
    return f;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand, multiplier, accumulator and
// iteration counter with load/step controls and a last-iteration flag.
module mul_shift_add_dp
  import exe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [N-1:0] mcand_i,
  input  logic [N-1:0] mplier_i,
  input  logic [N-1:0] acc_i,
  output logic [N-1:0] acc_nxt_o,
  output logic         last_o
);

  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = acc_i;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Stop once the remaining multiplier bits are all zero
  assign last_o = (mplier_q[N-1:1] == '0) |
                  (cnt_q == CNT_W'(N-1));

  assign acc_nxt_o = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/exe_mul_sequencer.sv
// Multi-cycle MUL sequencer beside the EXE ALU: stalls the front end while
// iterating. Define MUL_ACC_EN to add the AccIn/accIn_sel MLA inputs.
module exe_mul_sequencer
  import exe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [N-1:0] Val1In,
  input  logic [N-1:0] Val2In,
  input  logic         SIn,
  input  logic [3:0]   statusIn,
`ifdef MUL_ACC_EN
  input  logic [N-1:0] AccIn,
  input  logic         accIn_sel,
`endif
  output logic         stall,
  output logic         done,
  output logic [N-1:0] ResOut,
  output logic [3:0]   statusOut,
  output logic         statusWe
);

  mul_state_e   state_q, state_d;
  logic         s_q;
  logic [N-1:0] res_q;
  logic [3:0]   stat_q;
  logic [N-1:0] acc_init;
  logic [N-1:0] acc_nxt;
  logic         last;
  logic         accept;
  logic         finish;
  logic         in_run;

  assign in_run = (state_q == RUN);
  assign accept = (state_q == IDLE) & start & ~flush;
  assign finish = in_run & last & ~flush;

`ifdef MUL_ACC_EN
  assign acc_init = accIn_sel ? AccIn : '0;
`else
  assign acc_init = '0;
`endif

  mul_shift_add_dp #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (in_run),
    .mcand_i   (Val1In),
    .mplier_i  (Val2In),
    .acc_i     (acc_init),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (accept) state_d = RUN;
      (state_q == RUN): begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      res_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) s_q <= SIn;
      // Result registers update only on a completed, unflushed run
      if (finish) begin
        res_q  <= acc_nxt;
        stat_q <= mul_flags(statusIn, acc_nxt[N-1], acc_nxt == '0);
      end
    end
  end

  assign stall     = in_run | accept;
  assign done      = (state_q == DONE);
  assign statusWe  = done & s_q;
  assign ResOut    = res_q;
  assign statusOut = stat_q;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Scoreboard bench for exe_mul_sequencer: directed multiplies, flush,
// ignored start, async reset and (with MUL_ACC_EN) MLA cases.
module tb_exe_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] Val1In = '0;
  logic [31:0] Val2In = '0;
  logic        SIn = 1'b0;
  logic [3:0]  statusIn = '0;
`ifdef MUL_ACC_EN
  logic [31:0] AccIn = '0;
  logic        accIn_sel = 1'b0;
`endif
  logic        stall;
  logic        done;
  logic [31:0] ResOut;
  logic [3:0]  statusOut;
  logic        statusWe;

  exe_mul_sequencer #(.N(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .Val1In    (Val1In),
    .Val2In    (Val2In),
    .SIn       (SIn),
    .statusIn  (statusIn),
`ifdef MUL_ACC_EN
    .AccIn     (AccIn),
    .accIn_sel (accIn_sel),
`endif
    .stall     (stall),
    .done      (done),
    .ResOut    (ResOut),
    .statusOut (statusOut),
    .statusWe  (statusWe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  stat;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sbq.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("res", ResOut, e.res);
        chk("status", 32'(statusOut), 32'(e.stat));
        chk("status_we", 32'(statusWe), 32'(e.we));
        chk("stall_done", 32'(stall), 32'd0);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [3:0] st,
                       input logic sel, input logic [31:0] acc);
    Val1In   = a;
    Val2In   = b;
    SIn      = s;
    statusIn = st;
`ifdef MUL_ACC_EN
    accIn_sel = sel;
    AccIn     = acc;
`else
    if (sel && acc != 0) $display("note: MLA operands unused");
`endif
  endtask

  task automatic do_mul(input string name,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [3:0] st,
                        input logic sel, input logic [31:0] acc,
                        input logic [31:0] er, input logic [3:0] es,
                        input int runs);
    exp_t e;
    int   n;
    bit   got;
    @(posedge clk);
    #1;
    drive(a, b, s, st, sel, acc);
    start = 1'b1;
    @(negedge clk);
    chk({name, "_stall_issue"}, 32'(stall), 32'd1);
    e.res  = er;
    e.stat = es;
    e.we   = s;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n   = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      chk({name, "_stall_run"}, 32'(stall), 32'd1);
      n++;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, n, runs);
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(statusWe), 32'd0);
    chk("rst_res", ResOut, 32'd0);
    chk("rst_status", 32'(statusOut), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_mul("m3x5", 32'd3, 32'd5, 1'b1, 4'b0011, 1'b0, 32'd0,
           32'd15, 4'b0011, 3);
    do_mul("m7x0", 32'd7, 32'd0, 1'b1, 4'b0000, 1'b0, 32'd0,
           32'd0, 4'b0100, 1);
    do_mul("mffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0101,
           1'b0, 32'd0, 32'h00000001, 4'b0001, 32);
    do_mul("mneg", 32'hFFFFFFFF, 32'd2, 1'b1, 4'b0010, 1'b0, 32'd0,
           32'hFFFFFFFE, 4'b1010, 2);

    // Flush in the 10th RUN cycle
    @(posedge clk);
    #1;
    drive(32'd2, 32'h80000000, 1'b1, 4'b0000, 1'b0, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_in", 32'(stall), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_we", 32'(statusWe), 32'd0);
    chk("flush_res_hold", ResOut, 32'hFFFFFFFE);
    do_mul("m6x7", 32'd6, 32'd7, 1'b1, 4'b1100, 1'b0, 32'd0,
           32'd42, 4'b0000, 3);

    // Start pulsed during RUN must be ignored
    @(posedge clk);
    #1;
    drive(32'd3, 32'd5, 1'b1, 4'b0011, 1'b0, 32'd0);
    start = 1'b1;
    begin
      exp_t e;
      e.res  = 32'd15;
      e.stat = 4'b0011;
      e.we   = 1'b1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    Val1In = 32'd100;
    Val2In = 32'd100;
    @(posedge clk);
    #1;
    start  = 1'b0;
    Val1In = 32'd3;
    Val2In = 32'd5;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin
          got = 1;
          break;
        end
      end
      chk("poke_done_seen", 32'(got), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("poke_no_requeue", 32'(done), 32'd0);

    // Asynchronous reset in the middle of a run
    @(posedge clk);
    #1;
    drive(32'd5, 32'h000000FF, 1'b1, 4'b0000, 1'b0, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_stall", 32'(stall), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_res", ResOut, 32'd0);
    chk("mrst_status", 32'(statusOut), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_mul("mwrap", 32'h00010000, 32'h00010000, 1'b1, 4'b1111,
           1'b0, 32'd0, 32'd0, 4'b0111, 17);

`ifdef MUL_ACC_EN
    do_mul("mla34", 32'd4, 32'd6, 1'b1, 4'b0000, 1'b1, 32'd10,
           32'd34, 4'b0000, 3);
    do_mul("mla0", 32'd5, 32'd0, 1'b1, 4'b1000, 1'b1, 32'd0,
           32'd0, 4'b0100, 1);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
